// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, RV32 sizing, fixed wait states.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned H/HU/W fault instead of being force-aligned.
//
// state  | meaning
// IDLE   | ready for a request; accepting latches it
// WAIT   | counting down wait states before the access
// RESP   | response held until rsp_ready
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state_q, state_d;

    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          commit, cur_write, is_b, is_h, is_w, bad_f3, oor, misalign, fault, mem_we;
    logic [31:0]   cur_addr, cur_wdata, rd_word, shifted, load_data, wr_data;
    logic [2:0]    cur_funct3;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [AW-1:0] word_idx;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE) && !rst;
        rsp_valid = (state_q == S_RESP);
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With zero wait states the access happens on the accept edge, so use the live request.
    assign commit     = (state_d == S_RESP) && (state_q != S_RESP);
    assign cur_write  = (state_q == S_IDLE) ? req_write  : write_q;
    assign cur_addr   = (state_q == S_IDLE) ? req_addr   : addr_q;
    assign cur_funct3 = (state_q == S_IDLE) ? req_funct3 : funct3_q;
    assign cur_wdata  = (state_q == S_IDLE) ? req_wdata  : wdata_q;

    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (state_q == S_IDLE && req_valid) begin
            write_d  = req_write;
            addr_d   = req_addr;
            funct3_d = req_funct3;
            wdata_d  = req_wdata;
            cnt_d    = WAIT_LOAD;
        end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end

        is_b   = (cur_funct3[1:0] == 2'b00);
        is_h   = (cur_funct3[1:0] == 2'b01);
        is_w   = (cur_funct3[1:0] == 2'b10);
        bad_f3 = (cur_funct3 == 3'b011) || (cur_funct3[2:1] == 2'b11) || (cur_write && cur_funct3[2]);
        oor    = (cur_addr >> (AW + 2)) != 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (is_h && cur_addr[0]) || (is_w && (cur_addr[1:0] != 2'b00));
        lane     = cur_addr[1:0];
`else
        misalign = 1'b0;
        lane     = is_w ? 2'b00 : (is_h ? {cur_addr[1], 1'b0} : cur_addr[1:0]);
`endif
        fault    = oor || bad_f3 || misalign;
        word_idx = cur_addr[AW+1:2];
        rd_word  = mem[word_idx];
        shifted  = rd_word >> {lane, 3'b000};

        case (cur_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase

        wr_data = cur_wdata << {lane, 3'b000};
        be      = is_b ? (4'b0001 << lane) : (is_h ? (4'b0011 << lane) : 4'b1111);
        mem_we  = commit && cur_write && !fault && !rst;

        if (commit) begin
            rsp_rdata_d = (fault || cur_write) ? 32'd0 : load_data;
            rsp_err_d   = fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            write_q     <= write_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;
    localparam int WC = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    logic        rst2, v2, rdy2, w2, rv2, rr2, re2;
    logic [31:0] a2, wd2, rd2;
    logic [2:0]  f2;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst2), .req_valid(v2), .req_ready(rdy2),
        .req_write(w2), .req_addr(a2), .req_funct3(f2),
        .req_wdata(wd2), .rsp_valid(rv2), .rsp_ready(rr2),
        .rsp_rdata(rd2), .rsp_err(re2));

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    bit pending = 1'b0;
    bit mon_en  = 1'b0;
    logic [32:0] exp_q[$];
    logic [7:0]  mem_m [0:4095];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte-addressed memory, sizes 1/2/4, errors checked before any update.
    function automatic void model(input bit wr, input logic [31:0] a, input logic [2:0] f3,
                                  input logic [31:0] wd, output bit err, output logic [31:0] rd);
        int size;
        logic [31:0] ea, v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]) || (a >= 32'd4096);
        ea   = a;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((a % 32'(size)) != 32'd0) err = 1'b1;
`else
        ea = a - (a % 32'(size));
`endif
        rd = 32'd0;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < size; i++) mem_m[12'(ea + 32'(i))] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[12'(ea + 32'(i))];
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            check("req_ready", 32'(req_ready), 32'(!pending));
            if (rsp_valid && exp_q.size() > 0) begin
                check("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
                check("rsp_err", 32'(rsp_err), 32'(exp_q[0][32]));
            end else if (rsp_valid) begin
                check("rsp_valid_unexpected", 32'(rsp_valid), 32'd0);
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int stall,
                          output bit e, output logic [31:0] r);
        int c0, n;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        model(wr, a, f3, wd, e, r);
        if (!req_ready) begin
            check("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        exp_q.push_back({e, r});
        req_valid = 1'b1; req_write = wr; req_addr = a; req_funct3 = f3; req_wdata = wd;
        tick();
        c0 = cycle;
        pending = 1'b1;
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom;
        req_funct3 = 3'($urandom); req_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        check("rsp_latency", 32'(cycle - c0), 32'(WC));
        repeat (stall) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        pending = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic dir(input string name, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input int stall, input bit xe, input logic [31:0] xr);
        bit e;
        logic [31:0] r;
        do_req(wr, a, f3, wd, stall, e, r);
        check({name, "_err"}, 32'(e), 32'(xe));
        check({name, "_rdata"}, r, xr);
    endtask

    task automatic req2(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        v2 = 1'b1; w2 = wr; a2 = a; f2 = 3'b010; wd2 = wd;
        tick();
        v2 = 1'b0;
    endtask

    task automatic finish_rsp2(input string name, input logic [31:0] xr);
        int n;
        n = 0;
        while (!rv2 && n < 20) begin tick(); n++; end
        check({name, "_valid"}, 32'(rv2), 32'd1);
        check({name, "_rdata"}, rd2, xr);
        check({name, "_err"}, 32'(re2), 32'd0);
        rr2 = 1'b1;
        tick();
        rr2 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        logic [31:0] r;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
        req_wdata = 32'd0; rsp_ready = 1'b0;
        rst2 = 1'b1; v2 = 1'b0; w2 = 1'b0; a2 = 32'd0; f2 = 3'd0; wd2 = 32'd0; rr2 = 1'b0;

        tick();
        check("reset_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("reset_req_ready2", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_req_ready", 32'(req_ready), 32'd1);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_reset_rsp_rdata", rsp_rdata, 32'd0);
        check("post_reset_rsp_err", 32'(rsp_err), 32'd0);
        mon_en = 1'b1;

        dir("sw_10",   1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 1'b0, 32'h0);
        dir("sb_11",   1'b1, 32'h11, 3'b000, 32'h00000055, 0, 1'b0, 32'h0);
        dir("lw_10",   1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b0, 32'hDEAD55EF);
        dir("lb_13",   1'b0, 32'h13, 3'b000, 32'h0, 1, 1'b0, 32'hFFFFFFDE);
        dir("lbu_13",  1'b0, 32'h13, 3'b100, 32'h0, 0, 1'b0, 32'h000000DE);
        dir("lh_12",   1'b0, 32'h12, 3'b001, 32'h0, 2, 1'b0, 32'hFFFFDEAD);
        dir("lhu_12",  1'b0, 32'h12, 3'b101, 32'h0, 0, 1'b0, 32'h0000DEAD);
        dir("bp_lw",   1'b0, 32'h10, 3'b010, 32'h0, 5, 1'b0, 32'hDEAD55EF);
        dir("oor_lw",  1'b0, 32'h1000, 3'b010, 32'h0, 0, 1'b1, 32'h0);
        dir("sbu_err", 1'b1, 32'h10, 3'b100, 32'h11223344, 0, 1'b1, 32'h0);
        dir("lw_keep", 1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b0, 32'hDEAD55EF);
        dir("f3_011",  1'b0, 32'h10, 3'b011, 32'h0, 0, 1'b1, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        dir("mis_lw",  1'b0, 32'h12, 3'b010, 32'h0, 0, 1'b1, 32'h0);
`else
        dir("mis_lw",  1'b0, 32'h12, 3'b010, 32'h0, 0, 1'b0, 32'hDEAD55EF);
`endif

        for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i * 4), 3'b010, $urandom, 0, e, r);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'h1000 + $urandom_range(0, 255) : (32'h2000 | $urandom);
            else
                a = $urandom_range(0, 255);
            do_req(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 3)), e, r);
        end
        mon_en = 1'b0;

        rst2 = 1'b0;
        tick();
        req2(1'b1, 32'h20, 32'hCAFEF00D);
        finish_rsp2("pre_sw", 32'h0);
        check("rst_ready_before", 32'(rdy2), 32'd1);
        req2(1'b1, 32'h20, 32'h12345678);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rst_no_rsp", 32'(rv2), 32'd0);
            tick();
        end
        req2(1'b0, 32'h20, 32'h0);
        finish_rsp2("rst_old_lw", 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder that terminates the load/store request interface driven by the pipeline's memory stage. It accepts one request at a time over a valid/ready handshake and holds a word-organised RAM. It applies RISC-V byte/halfword/word sizing, with sign or zero extension on loads. Each request gets exactly one response over a second valid/ready handshake, after a configurable number of wait states.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 1, wait states between accept and response; legal range 0-15.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data, extended; 0 for stores and errors.
- rsp_err  out  1  access fault.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready = 1.
  - When req_valid is high, latch write, addr, funct3 and wdata.
  - Go to WAIT if WAIT_CYCLES > 0, else go to RESP.
- **WAIT**
  - A 4-bit counter loads WAIT_CYCLES-1 on accept and decrements each cycle.
  - Go to RESP when the counter reaches 0.
- **Entry to RESP** (a single edge) does all of the following:
  - Evaluates the error condition.
  - Commits the store to RAM with byte enables.
  - Registers rsp_rdata and rsp_err.
- **RESP**
  - rsp_valid = 1. rsp_rdata and rsp_err stay stable until the handshake completes.
  - Go to IDLE on the edge where rsp_ready is high.
- **Word index** = req_addr[log2(DEPTH_WORDS)+1:2].
- **Loads**
  - Select the byte or halfword with addr[1:0].
  - B and H sign-extend; BU and HU zero-extend; W returns the word unchanged.
- **Stores**
  - B writes lane addr[1:0] from wdata[7:0].
  - H writes lanes addr[1]*2 +0/+1 from wdata[15:0].
  - W writes all four lanes.
- **Errors** set rsp_err = 1, rsp_rdata = 0, and perform no RAM write:
  - any req_addr bit above the word-index range is set (out of range);
  - funct3 is 011, 110 or 111;
  - funct3 is 100 or 101 on a store;
  - misalignment, per Configuration.
- RAM contents are not reset.

## Timing
- Reset values: req_ready = 0 during reset and 1 in the first cycle after it; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; state = IDLE; counter = 0.
- A request is accepted at edge E0, where req_valid and req_ready are both high.
- rsp_valid rises in the cycle after edge E0 + WAIT_CYCLES.
  - WAIT_CYCLES = 0 gives a 1-cycle latency.
- No overlap between requests:
  - req_ready = 0 from E0 until the response handshake edge.
  - req_ready returns to 1 in the cycle after that edge.
  - Peak throughput is one request per WAIT_CYCLES + 2 cycles.
- rsp_ready held low stalls indefinitely in RESP with outputs held.
- A store is visible to a load accepted in any later cycle.
- rst asserted mid-operation:
  - The FSM goes to IDLE and any pending response is dropped.
  - A store not yet committed (state WAIT or earlier) is discarded.
  - A committed store stays in RAM.
- req inputs are ignored when req_ready = 0.

## Configuration
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: the following give rsp_err = 1 with no write and rdata 0:
  - H or HU with addr[0] = 1;
  - W with addr[1:0] != 0.
- Undefined: misaligned accesses are force-aligned and never flag misalignment.
  - H/HU clear addr[0]; W clears addr[1:0].
  - Out-of-range and funct3 errors still apply.

## Test plan
- **Reset / handshake, WAIT_CYCLES=1:**
  - Hold rst for 2 cycles, then release -> req_ready = 1 and rsp_valid = 0 in the first cycle after release.
  - Store W 0xDEADBEEF to 0x10 -> rsp_valid in the 2nd cycle after accept, rsp_err = 0, rsp_rdata = 0.
- **Byte/half sizing:**
  - After the word above, store B 0x55 to 0x11 -> load W 0x10 returns 0xDEAD55EF.
  - Load B 0x13 returns 0xFFFFFFDE; load BU 0x13 returns 0x000000DE.
  - Load H 0x12 returns 0xFFFFDEAD; load HU 0x12 returns 0x0000DEAD.
- **Backpressure:**
  - Hold rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0.
  - Raise rsp_ready -> req_ready = 1 on the next cycle.
- **Errors:**
  - Load at 0x00001000 with DEPTH_WORDS = 1024 -> rsp_err = 1, rsp_rdata = 0.
  - Store with funct3 = 100 -> rsp_err = 1, RAM unchanged.
  - Load with funct3 = 011 -> rsp_err = 1.
- **Misalignment:**
  - With DMEM_MISALIGN_TRAP_EN, load W at 0x12 -> rsp_err = 1.
  - Without it, the same load returns the word at 0x10 with rsp_err = 0.
- **Reset mid-operation, WAIT_CYCLES=3:**
  - Accept store W 0x12345678 at 0x20, assert rst one cycle later -> no response.
  - A subsequent load W 0x20 returns the old contents.
